// File: rtl/ex_mem_pipeline_reg_pkg.sv
// Shared definitions for the EX->MEM pipeline register.
//   DATA_W_DEF     : default width of branch target, ALU result and store data
//   REG_ADDR_W_DEF : default width of the destination register index
//   exMemCtrl_t    : the five memory/writeback control bits carried to MEM
package ex_mem_pipeline_reg_pkg;

   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned REG_ADDR_W_DEF = 5;

   typedef struct packed {
      logic memRead;
      logic memWrite;
      logic branch;
      logic regWrite;
      logic memToReg;
   } exMemCtrl_t;

   localparam int unsigned CTRL_W = $bits(exMemCtrl_t);

endpackage

// File: rtl/ex_mem_pipeline_reg_field.sv
// pipe_field_reg: generic pipeline field register.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears q
//   en  : load d into q on the clock edge
//   clr : synchronous clear, takes priority over en
//   d   : next value
//   q   : registered value
module pipe_field_reg #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ex_mem_pipeline_reg.sv
// ex_mem_pipeline_reg: EX->MEM pipeline register of the 5-stage core.
//   CLK, RST      : clock and asynchronous active-high reset
//   hit           : 1 = advance payload, 0 = hold payload (stall)
//   flush         : 1 = clear the five control bits (bubble), priority over hit
//   branchTarget, zeroFlag, ALUResult, readData2, writeReg : EX data fields
//   MemRead, MemWrite, Branch, RegWrite, MemToReg         : MEM/WB controls
//   <name>Out     : registered copy of each input above
//   hitOut        : registered hit, captured on every edge
module ex_mem_pipeline_reg
   import ex_mem_pipeline_reg_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  hit,
   input  logic                  flush,
   input  logic [DATA_W-1:0]     branchTarget,
   input  logic                  zeroFlag,
   input  logic [DATA_W-1:0]     ALUResult,
   input  logic [DATA_W-1:0]     readData2,
   input  logic [REG_ADDR_W-1:0] writeReg,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  Branch,
   input  logic                  RegWrite,
   input  logic                  MemToReg,
   output logic [DATA_W-1:0]     branchTargetOut,
   output logic                  zeroFlagOut,
   output logic [DATA_W-1:0]     ALUResultOut,
   output logic [DATA_W-1:0]     readData2Out,
   output logic [REG_ADDR_W-1:0] writeRegOut,
   output logic                  MemReadOut,
   output logic                  MemWriteOut,
   output logic                  BranchOut,
   output logic                  RegWriteOut,
   output logic                  MemToRegOut,
   output logic                  hitOut
);

   localparam int unsigned DATA_GRP_W = 3 * DATA_W + 1 + REG_ADDR_W;

   logic [DATA_GRP_W-1:0] dataIn;
   logic [DATA_GRP_W-1:0] dataQ;
   exMemCtrl_t            ctrlIn;
   exMemCtrl_t            ctrlQ;

   assign dataIn = {branchTarget, zeroFlag, ALUResult, readData2, writeReg};

   always_comb begin
      ctrlIn          = '0;
      ctrlIn.memRead  = MemRead;
      ctrlIn.memWrite = MemWrite;
      ctrlIn.branch   = Branch;
      ctrlIn.regWrite = RegWrite;
      ctrlIn.memToReg = MemToReg;
   end

   // Data fields only follow hit; flush does not touch them.
   pipe_field_reg #(.WIDTH(DATA_GRP_W)) dataReg (
      .clk (CLK),
      .rst (RST),
      .en  (hit),
      .clr (1'b0),
      .d   (dataIn),
      .q   (dataQ)
   );

   // Controls: flush clears even while stalled, otherwise follow hit.
   pipe_field_reg #(.WIDTH(CTRL_W)) ctrlReg (
      .clk (CLK),
      .rst (RST),
      .en  (hit),
      .clr (flush),
      .d   (ctrlIn),
      .q   (ctrlQ)
   );

   // hit itself is captured unconditionally.
   pipe_field_reg #(.WIDTH(1)) hitReg (
      .clk (CLK),
      .rst (RST),
      .en  (1'b1),
      .clr (1'b0),
      .d   (hit),
      .q   (hitOut)
   );

   assign {branchTargetOut, zeroFlagOut, ALUResultOut, readData2Out, writeRegOut} = dataQ;

   assign MemReadOut  = ctrlQ.memRead;
   assign MemWriteOut = ctrlQ.memWrite;
   assign BranchOut   = ctrlQ.branch;
   assign RegWriteOut = ctrlQ.regWrite;
   assign MemToRegOut = ctrlQ.memToReg;

endmodule

// File: tb/tb_ex_mem_pipeline_reg.sv
// Directed bench for ex_mem_pipeline_reg.
module tb_ex_mem_pipeline_reg;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        hit = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] branchTarget = '0;
   logic        zeroFlag = 1'b0;
   logic [31:0] ALUResult = '0;
   logic [31:0] readData2 = '0;
   logic [4:0]  writeReg = '0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic        Branch = 1'b0;
   logic        RegWrite = 1'b0;
   logic        MemToReg = 1'b0;

   logic [31:0] branchTargetOut;
   logic        zeroFlagOut;
   logic [31:0] ALUResultOut;
   logic [31:0] readData2Out;
   logic [4:0]  writeRegOut;
   logic        MemReadOut;
   logic        MemWriteOut;
   logic        BranchOut;
   logic        RegWriteOut;
   logic        MemToRegOut;
   logic        hitOut;

   int cmpCnt = 0;
   int errCnt = 0;

   ex_mem_pipeline_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .hit             (hit),
      .flush           (flush),
      .branchTarget    (branchTarget),
      .zeroFlag        (zeroFlag),
      .ALUResult       (ALUResult),
      .readData2       (readData2),
      .writeReg        (writeReg),
      .MemRead         (MemRead),
      .MemWrite        (MemWrite),
      .Branch          (Branch),
      .RegWrite        (RegWrite),
      .MemToReg        (MemToReg),
      .branchTargetOut (branchTargetOut),
      .zeroFlagOut     (zeroFlagOut),
      .ALUResultOut    (ALUResultOut),
      .readData2Out    (readData2Out),
      .writeRegOut     (writeRegOut),
      .MemReadOut      (MemReadOut),
      .MemWriteOut     (MemWriteOut),
      .BranchOut       (BranchOut),
      .RegWriteOut     (RegWriteOut),
      .MemToRegOut     (MemToRegOut),
      .hitOut          (hitOut)
   );

   always #5 CLK = ~CLK;

   // Concatenated views: controls {MemRead,MemWrite,Branch,RegWrite,MemToReg}
   wire [4:0]   ctrlOut = {MemReadOut, MemWriteOut, BranchOut, RegWriteOut, MemToRegOut};
   wire [107:0] allOut  = {branchTargetOut, zeroFlagOut, ALUResultOut, readData2Out,
                           writeRegOut, ctrlOut, hitOut};

   task automatic test_reset();
      @(negedge CLK);
      hit = 1'b1; branchTarget = 32'hDEAD_BEEF; zeroFlag = 1'b1; ALUResult = 32'h5555;
      readData2 = 32'hAAAA; writeReg = 5'h1F;
      {MemRead, MemWrite, Branch, RegWrite, MemToReg} = 5'b11111;
      #1 RST = 1'b1;
      #1;
      cmpCnt++;
      if (allOut !== '0) begin
         errCnt++;
         $display("FAIL reset_async: got %h want 0", allOut);
      end
      @(posedge CLK); #1;
      cmpCnt++;
      if (allOut !== '0) begin
         errCnt++;
         $display("FAIL reset_held: got %h want 0", allOut);
      end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_capture();
      @(negedge CLK);
      hit = 1'b1; flush = 1'b0;
      branchTarget = 32'h84; zeroFlag = 1'b0; ALUResult = 32'h20; readData2 = 32'h3;
      writeReg = 5'b01010;
      {MemRead, MemWrite, Branch, RegWrite, MemToReg} = 5'b00101;
      @(posedge CLK); #1;
      cmpCnt++;
      if (branchTargetOut !== 32'h84) begin
         errCnt++; $display("FAIL cap_branchTarget: got %h want 84", branchTargetOut);
      end
      cmpCnt++;
      if (zeroFlagOut !== 1'b0) begin
         errCnt++; $display("FAIL cap_zeroFlag: got %b want 0", zeroFlagOut);
      end
      cmpCnt++;
      if (ALUResultOut !== 32'h20) begin
         errCnt++; $display("FAIL cap_ALUResult: got %h want 20", ALUResultOut);
      end
      cmpCnt++;
      if (readData2Out !== 32'h3) begin
         errCnt++; $display("FAIL cap_readData2: got %h want 3", readData2Out);
      end
      cmpCnt++;
      if (writeRegOut !== 5'b01010) begin
         errCnt++; $display("FAIL cap_writeReg: got %b want 01010", writeRegOut);
      end
      cmpCnt++;
      if (ctrlOut !== 5'b00101) begin
         errCnt++; $display("FAIL cap_ctrl: got %b want 00101", ctrlOut);
      end
      cmpCnt++;
      if (hitOut !== 1'b1) begin
         errCnt++; $display("FAIL cap_hitOut: got %b want 1", hitOut);
      end
   endtask

   task automatic test_stall();
      @(negedge CLK);
      hit = 1'b0; ALUResult = 32'hFFFF; readData2 = 32'h77; zeroFlag = 1'b1;
      @(posedge CLK); #1;
      cmpCnt++;
      if (ALUResultOut !== 32'h20) begin
         errCnt++; $display("FAIL stall_ALUResult: got %h want 20", ALUResultOut);
      end
      cmpCnt++;
      if ({branchTargetOut, zeroFlagOut, readData2Out, writeRegOut, ctrlOut}
          !== {32'h84, 1'b0, 32'h3, 5'b01010, 5'b00101}) begin
         errCnt++;
         $display("FAIL stall_payload: got %h %b %h %b %b want 84 0 3 01010 00101",
                  branchTargetOut, zeroFlagOut, readData2Out, writeRegOut, ctrlOut);
      end
      cmpCnt++;
      if (hitOut !== 1'b0) begin
         errCnt++; $display("FAIL stall_hitOut: got %b want 0", hitOut);
      end
      @(negedge CLK);
      hit = 1'b1;
      @(posedge CLK); #1;
      cmpCnt++;
      if (ALUResultOut !== 32'hFFFF) begin
         errCnt++; $display("FAIL resume_ALUResult: got %h want ffff", ALUResultOut);
      end
      cmpCnt++;
      if ({zeroFlagOut, readData2Out, hitOut} !== {1'b1, 32'h77, 1'b1}) begin
         errCnt++;
         $display("FAIL resume_misc: got %b %h %b want 1 77 1", zeroFlagOut, readData2Out, hitOut);
      end
   endtask

   task automatic test_flush();
      @(negedge CLK);
      RegWrite = 1'b1; MemWrite = 1'b1; flush = 1'b1; hit = 1'b1;
      ALUResult = 32'h1234; writeReg = 5'h11;
      @(posedge CLK); #1;
      cmpCnt++;
      if (ctrlOut !== 5'b00000) begin
         errCnt++; $display("FAIL flush_ctrl: got %b want 00000", ctrlOut);
      end
      cmpCnt++;
      if ({ALUResultOut, writeRegOut} !== {32'h1234, 5'h11}) begin
         errCnt++;
         $display("FAIL flush_data: got %h %h want 1234 11", ALUResultOut, writeRegOut);
      end
   endtask

   task automatic test_flush_stall();
      // reload live controls first so the clear is observable
      @(negedge CLK);
      flush = 1'b0; hit = 1'b1;
      {MemRead, MemWrite, Branch, RegWrite, MemToReg} = 5'b01111;
      @(posedge CLK); #1;
      cmpCnt++;
      if (ctrlOut !== 5'b01111) begin
         errCnt++; $display("FAIL reload_ctrl: got %b want 01111", ctrlOut);
      end
      @(negedge CLK);
      hit = 1'b0; flush = 1'b1; ALUResult = 32'hBEEF; writeReg = 5'h03;
      @(posedge CLK); #1;
      cmpCnt++;
      if (ctrlOut !== 5'b00000) begin
         errCnt++; $display("FAIL flstall_ctrl: got %b want 00000", ctrlOut);
      end
      cmpCnt++;
      if ({ALUResultOut, writeRegOut, hitOut} !== {32'h1234, 5'h11, 1'b0}) begin
         errCnt++;
         $display("FAIL flstall_data: got %h %h %b want 1234 11 0",
                  ALUResultOut, writeRegOut, hitOut);
      end
   endtask

   task automatic test_async_reset();
      @(negedge CLK);
      hit = 1'b1; flush = 1'b0; MemRead = 1'b1;
      @(posedge CLK); #1;
      cmpCnt++;
      if ({ALUResultOut, ctrlOut} !== {32'hBEEF, 5'b11111}) begin
         errCnt++;
         $display("FAIL prearst_state: got %h %b want beef 11111", ALUResultOut, ctrlOut);
      end
      #1 RST = 1'b1;
      #1;
      cmpCnt++;
      if (allOut !== '0) begin
         errCnt++; $display("FAIL midcycle_reset: got %h want 0", allOut);
      end
      @(negedge CLK);
      RST = 1'b0;
      branchTarget = 32'h100; zeroFlag = 1'b0; ALUResult = 32'h44; readData2 = 32'h9;
      writeReg = 5'h07;
      {MemRead, MemWrite, Branch, RegWrite, MemToReg} = 5'b10011;
      @(posedge CLK); #1;
      cmpCnt++;
      if (allOut !== {32'h100, 1'b0, 32'h44, 32'h9, 5'h07, 5'b10011, 1'b1}) begin
         errCnt++; $display("FAIL post_reset_capture: got %h", allOut);
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_stall();
      test_flush();
      test_flush_stall();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
      $finish;
   end

endmodule
